// File: rtl/spike_rate_decoder_pkg.sv
// Shared widths, limits and FSM encodings for the spike rate decoder.
// Imported by the interface, the ISI timer and the top level.
package spike_rate_decoder_pkg;
   localparam int WIN_W_DEF = 8;
   localparam int CNT_W_DEF = 6;
   localparam int ISI_W_DEF = 8;

   localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;
   localparam logic [ISI_W_DEF-1:0] ISI_MAX = '1;

   localparam logic [0:0] ISI_NO_EVT = 1'b0;
   localparam logic [0:0] ISI_TIMING = 1'b1;

   localparam logic [0:0] OUT_EMPTY  = 1'b0;
   localparam logic [0:0] OUT_FULL   = 1'b1;

   typedef struct packed {
      logic [0:0] isi_state;
      logic [0:0] out_state;
   } dbg_state_t;
endpackage

// File: rtl/spike_rate_decoder_if.sv
// Result port: rate/ISI/saturation payload with valid/ready flow control.
// A result transfers on every cycle where out_valid & out_ready; payload is stable while out_valid & ~out_ready.
interface spike_rate_decoder_if
   import spike_rate_decoder_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int ISI_W = ISI_W_DEF
) ();
   logic [CNT_W-1:0] rate_out;
   logic [ISI_W-1:0] isi_out;
   logic             sat_out;
   logic             out_valid;
   logic             out_ready;

   modport master (output rate_out, output isi_out, output sat_out, output out_valid, input out_ready);
   modport slave  (input rate_out, input isi_out, input sat_out, input out_valid, output out_ready);
endinterface

// File: rtl/spike_rate_decoder_isi_timer.sv
// Inter-spike interval timer: saturating gap counter between events plus NO_EVT/TIMING FSM.
// o_isi_next is the value isi_q takes this cycle, so a window closing on an event sees the new ISI.
module spike_rate_decoder_isi_timer
   import spike_rate_decoder_pkg::*;
#(
   parameter int ISI_W = ISI_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_en,
   input  logic             i_event,
   output logic [ISI_W-1:0] o_isi_q,
   output logic [ISI_W-1:0] o_isi_next,
   output logic [0:0]       o_state
);
   logic [0:0]       r_state;
   logic [ISI_W-1:0] r_gap;
   logic [ISI_W-1:0] r_isi;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ISI_NO_EVT;
         r_gap   <= '0;
         r_isi   <= '0;
      end else if (i_en) begin
         case (r_state)
            ISI_NO_EVT: begin
               if (i_event) begin
                  r_state <= ISI_TIMING;
                  r_gap   <= ISI_W'(1);
               end
            end
            ISI_TIMING: begin
               if (i_event) begin
                  r_isi <= r_gap;
                  r_gap <= ISI_W'(1);
               end else if (r_gap != '1) begin
                  r_gap <= r_gap + ISI_W'(1);
               end
            end
            default: r_state <= ISI_NO_EVT;
         endcase
      end
   end

   assign o_isi_q    = r_isi;
   assign o_isi_next = (r_state == ISI_TIMING && i_event) ? r_gap : r_isi;
   assign o_state    = r_state;
endmodule

// File: rtl/spike_rate_decoder.sv
// Spike-train decoder: counts rising-edge events per programmable window and reports
// the count with the latest inter-spike interval through a valid/ready result register.
module spike_rate_decoder
   import spike_rate_decoder_pkg::*;
#(
   parameter int WIN_W = WIN_W_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int ISI_W = ISI_W_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_en,
   input  logic                 i_spike_in,
   input  logic [WIN_W-1:0]     i_window_len,
   spike_rate_decoder_if.master out_if,
   output logic                 o_dropped,
   output dbg_state_t           o_dbg_state
);
   logic             r_spike_q;
   logic [WIN_W-1:0] r_len_q;
   logic [WIN_W-1:0] r_win_cnt;
   logic [CNT_W-1:0] r_spk_cnt;
   logic             r_spk_ovf;
   logic [0:0]       r_out_state;
   logic [CNT_W-1:0] r_rate;
   logic [ISI_W-1:0] r_isi;
   logic             r_sat;
   logic             r_dropped;

   logic [WIN_W-1:0] w_len_cur;
   logic [WIN_W-1:0] w_last_idx;
   logic             w_event;
   logic             w_win_end;
   logic [CNT_W:0]   w_sum;
   logic             w_sat;
   logic [CNT_W-1:0] w_result;
   logic [ISI_W-1:0] w_isi_q;
   logic [ISI_W-1:0] w_isi_next;
   logic [0:0]       w_isi_state;

   // On a window's first cycle the live length is used, so 1-cycle windows close immediately.
   // A length of 0 wraps to all-ones, giving a 2^WIN_W cycle window.
   assign w_len_cur  = (r_win_cnt == '0) ? i_window_len : r_len_q;
   assign w_last_idx = w_len_cur - WIN_W'(1);
   assign w_event    = i_en & i_spike_in & ~r_spike_q;
   assign w_win_end  = i_en & (r_win_cnt == w_last_idx);

   // r_spk_ovf remembers events lost after the count pinned, so saturation is reported faithfully.
   assign w_sum    = {1'b0, r_spk_cnt} + (CNT_W+1)'(w_event);
   assign w_sat    = r_spk_ovf | w_sum[CNT_W];
   assign w_result = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

   spike_rate_decoder_isi_timer #(.ISI_W(ISI_W)) u_isi_timer (
      .clk        (clk),
      .reset      (reset),
      .i_en       (i_en),
      .i_event    (w_event),
      .o_isi_q    (w_isi_q),
      .o_isi_next (w_isi_next),
      .o_state    (w_isi_state)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_spike_q <= 1'b0;
         r_len_q   <= '0;
         r_win_cnt <= '0;
         r_spk_cnt <= '0;
         r_spk_ovf <= 1'b0;
      end else begin
         r_spike_q <= i_spike_in;
         if (i_en) begin
            if (r_win_cnt == '0) r_len_q <= i_window_len;
            if (w_win_end) begin
               r_win_cnt <= '0;
               r_spk_cnt <= '0;
               r_spk_ovf <= 1'b0;
            end else begin
               r_win_cnt <= r_win_cnt + WIN_W'(1);
               if (w_event) begin
                  if (r_spk_cnt == '1) r_spk_ovf <= 1'b1;
                  else                 r_spk_cnt <= r_spk_cnt + CNT_W'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_state <= OUT_EMPTY;
         r_rate      <= '0;
         r_isi       <= '0;
         r_sat       <= 1'b0;
         r_dropped   <= 1'b0;
      end else if (w_win_end && (r_out_state == OUT_EMPTY || out_if.out_ready)) begin
         r_out_state <= OUT_FULL;
         r_rate      <= w_result;
         r_isi       <= w_isi_next;
         r_sat       <= w_sat;
      end else if (w_win_end) begin
         r_dropped   <= 1'b1;
      end else if (r_out_state == OUT_FULL && out_if.out_ready) begin
         r_out_state <= OUT_EMPTY;
      end
   end

   assign out_if.rate_out  = r_rate;
   assign out_if.isi_out   = r_isi;
   assign out_if.sat_out   = r_sat;
   assign out_if.out_valid = (r_out_state == OUT_FULL);
   assign o_dropped        = r_dropped;

   assign o_dbg_state.isi_state = w_isi_state;
   assign o_dbg_state.out_state = r_out_state;

   logic w_unused;
   assign w_unused = ^w_isi_q;
endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: reset, rate/ISI windows, backpressure, saturation and enable freeze.
module tb_spike_rate_decoder;
  import spike_rate_decoder_pkg::*;

  logic       clk;
  logic       reset;
  logic       en;
  logic       spike;
  logic [7:0] window_len;
  logic       dropped;
  dbg_state_t dbg_state;

  int n_checks;
  int n_fail;
  logic [14:0] exp_q[$];

  spike_rate_decoder_if out_if ();

  spike_rate_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .i_en         (en),
    .i_spike_in   (spike),
    .i_window_len (window_len),
    .out_if       (out_if),
    .o_dropped    (dropped),
    .o_dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic sp, input logic e, input logic rdy);
    spike = sp;
    en = e;
    out_if.out_ready = rdy;
    tick();
  endtask

  task automatic do_reset(input logic [7:0] len);
    reset = 1'b1;
    en = 1'b0;
    spike = 1'b0;
    out_if.out_ready = 1'b1;
    window_len = len;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  // scoreboard
  task automatic check_result(input string tag, input logic [5:0] rate, input logic [7:0] isi, input logic sat);
    logic [14:0] e;
    exp_q.push_back({sat, isi, rate});
    e = exp_q.pop_front();
    check({tag, "_valid"}, 32'(out_if.out_valid), 32'd1);
    check({tag, "_rate"}, 32'(out_if.rate_out), 32'(e[5:0]));
    check({tag, "_isi"}, 32'(out_if.isi_out), 32'(e[13:6]));
    check({tag, "_sat"}, 32'(out_if.sat_out), 32'(e[14]));
  endtask

  initial begin
    int early;
    n_checks = 0;
    n_fail = 0;

    // 1: reset values and first-window latency
    do_reset(8'd10);
    check("rst_valid", 32'(out_if.out_valid), 32'd0);
    check("rst_rate", 32'(out_if.rate_out), 32'd0);
    check("rst_isi", 32'(out_if.isi_out), 32'd0);
    check("rst_sat", 32'(out_if.sat_out), 32'd0);
    check("rst_dropped", 32'(dropped), 32'd0);
    check("rst_dbg", 32'(dbg_state), 32'd0);
    early = 0;
    for (int c = 0; c < 9; c++) begin
      drive(1'b0, 1'b1, 1'b1);
      if (out_if.out_valid) early++;
    end
    check("t1_no_early_valid", 32'(early), 32'd0);
    drive(1'b0, 1'b1, 1'b1);
    check_result("t1_empty_window", 6'd0, 8'd0, 1'b0);

    // 2: spikes at 0,3,6,9 -> rate 4, isi 3, valid for one cycle
    do_reset(8'd10);
    for (int c = 0; c < 10; c++) drive(c % 3 == 0, 1'b1, 1'b1);
    check_result("t2", 6'd4, 8'd3, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    check("t2_valid_drop", 32'(out_if.out_valid), 32'd0);
    check("t2_dropped", 32'(dropped), 32'd0);

    // 3: held level counts once
    do_reset(8'd10);
    for (int c = 0; c < 10; c++) drive(c >= 2 && c <= 6, 1'b1, 1'b1);
    check_result("t3", 6'd1, 8'd0, 1'b0);

    // 4: backpressure across two windows
    do_reset(8'd10);
    for (int c = 0; c < 10; c++) drive(c % 3 == 0, 1'b1, 1'b0);
    check_result("t4_first", 6'd4, 8'd3, 1'b0);
    for (int c = 0; c < 10; c++) drive(c == 1 || c == 5, 1'b1, 1'b0);
    check_result("t4_held", 6'd4, 8'd3, 1'b0);
    check("t4_dropped", 32'(dropped), 32'd1);
    drive(1'b0, 1'b1, 1'b1);
    check("t4_accept_valid", 32'(out_if.out_valid), 32'd0);
    check("t4_accept_rate_hold", 32'(out_if.rate_out), 32'd4);
    check("t4_dropped_sticky", 32'(dropped), 32'd1);

    // 5a: 256-cycle window, 128 events -> saturation
    do_reset(8'd0);
    for (int c = 0; c < 256; c++) drive(c % 2 == 0, 1'b1, 1'b1);
    check_result("t5_sat", 6'd63, 8'd2, 1'b1);

    // 5b: 301-cycle gap saturates the ISI
    do_reset(8'd0);
    for (int c = 0; c < 256; c++) drive(c == 0, 1'b1, 1'b1);
    check_result("t5_win1", 6'd1, 8'd0, 1'b0);
    for (int c = 256; c < 512; c++) drive(c == 301, 1'b1, 1'b1);
    check_result("t5_isi_sat", 6'd1, 8'd255, 1'b0);

    // 6a: accept and reload on a window-end cycle
    do_reset(8'd10);
    for (int c = 0; c < 10; c++) drive(c == 0, 1'b1, 1'b0);
    check_result("t6_first", 6'd1, 8'd0, 1'b0);
    for (int c = 0; c < 9; c++) drive(c == 2 || c == 4 || c == 6, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    check_result("t6_reload", 6'd3, 8'd2, 1'b0);
    check("t6_no_drop", 32'(dropped), 32'd0);
    drive(1'b0, 1'b1, 1'b1);
    check("t6_valid_drop", 32'(out_if.out_valid), 32'd0);

    // 6b: en low for 5 cycles mid-window stretches the window
    do_reset(8'd10);
    early = 0;
    for (int c = 0; c < 6; c++) drive(c == 1 || c == 4, 1'b1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      drive(c == 0 || c == 1 || c == 3, 1'b0, 1'b1);
      if (out_if.out_valid) early++;
    end
    for (int c = 6; c < 9; c++) begin
      drive(1'b0, 1'b1, 1'b1);
      if (out_if.out_valid) early++;
    end
    check("t6_freeze_no_early", 32'(early), 32'd0);
    drive(1'b0, 1'b1, 1'b1);
    check_result("t6_freeze", 6'd2, 8'd3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
